// File: rtl/ccff_pkg.sv
// rtl/ccff_pkg.sv - shared types and constants for the configuration-chain loader
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE
  } ccff_state_e;

  localparam int CBX_CHAIN_LEN = 64;

  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// rtl/ccff_word_serializer.sv - word-to-bit serializer feeding ccff_head, one bit per shift enable
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = CBX_CHAIN_LEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              busy_i,
  input  logic              clear_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              head_o,
  output logic              shift_en_o
);

  localparam int WORDS     = words_per_pass(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_W;
  localparam int BW        = $clog2(WORD_W + 1);
  localparam int WW        = $clog2(WORDS + 1);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     words_q, words_d;
  logic              accept;
  logic              last_word;

  assign shift_en_o = busy_i && (cnt_q != '0);
  // Refill while the last bit of the current word is shifting keeps the chain busy every cycle.
  assign ready_o    = busy_i && (words_q != WW'(WORDS)) &&
                      ((cnt_q == '0) || ((cnt_q == BW'(1)) && shift_en_o));
  assign accept     = valid_i && ready_o;
  assign last_word  = (words_q == WW'(WORDS - 1));
  assign head_o     = sr_q[WORD_W-1];

  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    if (accept) begin
      sr_d    = data_i;
      cnt_d   = last_word ? BW'(LAST_BITS) : BW'(WORD_W);
      words_d = words_q + WW'(1);
    end else if (shift_en_o) begin
      // Holding the register on the final bit keeps ccff_head steady across a valid gap.
      if (cnt_q != BW'(1)) sr_d = sr_q << 1;
      cnt_d = cnt_q - BW'(1);
    end
    if (clear_i) words_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
    end
  end

endmodule

// File: rtl/ccff_stream_loader.sv
// rtl/ccff_stream_loader.sv - configuration-chain loader with optional read-back verify pass
module ccff_stream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = CBX_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_idx
);

  ccff_state_e      state_q;
  logic             busy_q, done_q, verify_q, err_q;
  logic [CNT_W-1:0] bit_cnt_q, err_idx_q;
  logic             start_ok, last_bit, pass_clear;

  assign start_ok   = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit   = ccff_shift_en && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign pass_clear = start_ok || ((state_q == ST_LOAD) && last_bit);

  ccff_word_serializer #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN)
  ) u_ser (
    .clk_i     (prog_clk),
    .rst_i     (pReset),
    .busy_i    (busy_q),
    .clear_i   (pass_clear),
    .data_i    (cfg_data),
    .valid_i   (cfg_valid),
    .ready_o   (cfg_ready),
    .head_o    (ccff_head),
    .shift_en_o(ccff_shift_en)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      verify_q  <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_start) begin
            state_q   <= ST_LOAD;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            verify_q  <= cfg_verify;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            bit_cnt_q <= '0;
          end
        end
        ST_LOAD: begin
          if (ccff_shift_en) begin
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (verify_q) begin
                state_q <= ST_VERIFY;
              end else begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_VERIFY: begin
          if (ccff_shift_en) begin
            // The tail now presents load-pass bit k, the same bit being resent on the head.
            if ((ccff_tail != ccff_head) && !err_q) begin
              err_q     <= 1'b1;
              err_idx_q <= bit_cnt_q;
            end
            if (last_bit) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// tb/tb_ccff_stream_loader.sv - scoreboard bench for the chain loader with 64- and 40-flop chain models
module tb_ccff_stream_loader;
  import ccff_pkg::*;

  localparam int N_A = 64;
  localparam int N_B = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        pReset = 1'b1, start_a = 1'b0, start_b = 1'b0, cfg_verify = 1'b0, cfg_valid = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        ready_a, head_a, sh_a, busy_a, done_a, err_a;
  logic        ready_b, head_b, sh_b, busy_b, done_b, err_b;
  logic [6:0]  eidx_a;
  logic [5:0]  eidx_b;
  logic [N_A-1:0] chain_a = '0, nxt_a;
  logic [N_B-1:0] chain_b = '0;
  bit          stuck_a = 1'b0;

  ccff_stream_loader #(.WORD_W(32), .CHAIN_LEN(N_A)) dut_a (
    .prog_clk(clk), .pReset(pReset), .cfg_start(start_a), .cfg_verify(cfg_verify),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_a), .ccff_head(head_a),
    .ccff_tail(chain_a[0]), .ccff_shift_en(sh_a), .busy(busy_a), .done(done_a),
    .err(err_a), .err_idx(eidx_a));

  ccff_stream_loader #(.WORD_W(32), .CHAIN_LEN(N_B)) dut_b (
    .prog_clk(clk), .pReset(pReset), .cfg_start(start_b), .cfg_verify(cfg_verify),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(ready_b), .ccff_head(head_b),
    .ccff_tail(chain_b[0]), .ccff_shift_en(sh_b), .busy(busy_b), .done(done_b),
    .err(err_b), .err_idx(eidx_b));

  // Chain models: index k ends up holding stream bit k, index 0 is the tail.
  always @(posedge clk) begin
    if (sh_a) begin
      nxt_a = {head_a, chain_a[N_A-1:1]};
      if (stuck_a) nxt_a[20] = 1'b0;
      chain_a <= nxt_a;
    end
    if (sh_b) chain_b <= {head_b, chain_b[N_B-1:1]};
  end

  int n_checks = 0, n_fail = 0;
  int cyc = 0, shifts_a = 0, shifts_b = 0, last_sh_a = 0, done_cyc_a = 0, err_rise_a = -1;
  int hs_a = 0, hs_b = 0;
  bit done_seen_a = 1'b0, err_seen_a = 1'b0;
  logic sh_prev_a = 1'b0, hsk_prev_a = 1'b0, head_prev_a = 1'b0, rst_prev = 1'b1;
  bit q_a[$];
  bit q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (err_a && !err_seen_a) begin
      err_seen_a = 1'b1;
      err_rise_a = shifts_a;
    end
    if (done_a && !done_seen_a) begin
      done_seen_a = 1'b1;
      done_cyc_a  = cyc;
    end
    if (busy_a && !rst_prev && !sh_prev_a && !hsk_prev_a)
      check("head_hold_a", 64'(head_a), 64'(head_prev_a));
    if (sh_a) begin
      shifts_a++;
      last_sh_a = cyc;
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_extra_shift_a: shift at cycle %0d with nothing expected", cyc);
      end else check("sb_head_a", 64'(head_a), 64'(q_a.pop_front()));
    end
    if (sh_b) begin
      shifts_b++;
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_extra_shift_b: shift at cycle %0d with nothing expected", cyc);
      end else check("sb_head_b", 64'(head_b), 64'(q_b.pop_front()));
    end
    sh_prev_a   = sh_a;
    hsk_prev_a  = cfg_valid && ready_a;
    head_prev_a = head_a;
    rst_prev    = pReset;
  end

  task automatic send_word(input bit to_b, input logic [31:0] w, input int nbits);
    int t = 0;
    bit ok = 1'b0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (to_b ? ready_b : ready_a) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: word %0h not accepted, required within 200 cycles", w);
    end else begin
      for (int i = 0; i < nbits; i++) begin
        if (to_b) q_b.push_back(w[31-i]);
        else      q_a.push_back(w[31-i]);
      end
      if (to_b) hs_b++;
      else      hs_a++;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic start_session_a(input logic v, input bit with_valid, input logic [31:0] w);
    @(posedge clk); #1;
    cfg_verify = v;
    start_a    = 1'b1;
    if (with_valid) begin
      cfg_valid = 1'b1;
      cfg_data  = w;
    end
    @(negedge clk);
    if (with_valid) check("ready_idle_start", 64'(ready_a), 64'd0);
    @(posedge clk); #1;
    start_a = 1'b0; cfg_valid = 1'b0; cfg_verify = 1'b0;
    @(negedge clk);
    check("start_busy", 64'(busy_a), 64'd1);
    check("start_done", 64'(done_a), 64'd0);
    check("start_err_cleared", 64'({eidx_a, err_a}), 64'd0);
    shifts_a = 0; hs_a = 0; done_seen_a = 1'b0; err_seen_a = 1'b0; err_rise_a = -1;
    @(posedge clk); #1;
  endtask

  task automatic finish_session_a(input int exp_sh, input int exp_hs, input logic exp_err,
                                  input logic [6:0] exp_idx);
    int t = 0;
    while (!done_a && t < 400) begin
      @(negedge clk); #1;
      t++;
    end
    if (!done_a) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: done still 0 after %0d cycles, required 1", t);
    end
    check("shift_count", 64'(shifts_a), 64'(exp_sh));
    check("handshakes", 64'(hs_a), 64'(exp_hs));
    check("done_after_last_shift", 64'(done_cyc_a), 64'(last_sh_a + 1));
    check("err", 64'(err_a), 64'(exp_err));
    check("err_idx", 64'(eidx_a), 64'(exp_idx));
    if (exp_err) check("err_rise_shift", 64'(err_rise_a), 64'(N_A + int'(exp_idx) + 1));
    check("sb_drained", 64'(q_a.size()), 64'd0);
  endtask

  function automatic logic [63:0] exp_chain(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] s, c;
    s = {w0, w1};
    for (int k = 0; k < 64; k++) c[k] = s[63-k];
    return c;
  endfunction

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic        verify;
    int          gap;
    bit          stuck;
    int          exp_sh;
    int          exp_hs;
    logic        exp_err;
    logic [6:0]  exp_idx;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] byte_b;
    int t;

    vecs[0] = '{32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 0, 1'b0,  64, 2, 1'b0, 7'd0};
    vecs[1] = '{32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 5, 1'b0,  64, 2, 1'b0, 7'd0};
    vecs[2] = '{32'hA5A5_0F0F, 32'h1234_5678, 1'b1, 0, 1'b0, 128, 4, 1'b0, 7'd0};
    vecs[3] = '{32'h0000_0FFF, 32'hFFFF_0000, 1'b1, 0, 1'b1, 128, 4, 1'b1, 7'd20};
    vecs[4] = '{32'hDEAD_BEEF, 32'h0F1E_2D3C, 1'b1, 3, 1'b0, 128, 4, 1'b0, 7'd0};

    repeat (3) @(posedge clk);
    #1 pReset = 1'b0;
    @(negedge clk);
    check("reset_outputs_a", 64'({ready_a, head_a, sh_a, busy_a, done_a, err_a, eidx_a}), 64'd0);
    check("reset_outputs_b", 64'({ready_b, head_b, sh_b, busy_b, done_b, err_b, eidx_b}), 64'd0);
    @(posedge clk); #1;

    // Word offered together with cfg_start, then a cfg_start while busy that must be ignored.
    start_session_a(1'b0, 1'b1, 32'hA5A5_0F0F);
    send_word(1'b0, 32'hA5A5_0F0F, 32);
    start_a = 1'b1; cfg_verify = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; cfg_verify = 1'b0;
    send_word(1'b0, 32'h1234_5678, 32);
    finish_session_a(64, 2, 1'b0, 7'd0);
    check("chain_start_busy", chain_a, exp_chain(32'hA5A5_0F0F, 32'h1234_5678));

    // Reset in the middle of a load pass.
    start_session_a(1'b0, 1'b0, 32'h0);
    send_word(1'b0, 32'hC3C3_3C3C, 32);
    t = 0;
    while (shifts_a < 10 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check("pre_reset_shifts", 64'(shifts_a >= 10), 64'd1);
    @(posedge clk); #1 pReset = 1'b1;
    repeat (2) @(posedge clk);
    #1 pReset = 1'b0;
    @(negedge clk);
    check("midload_reset_outputs", 64'({ready_a, head_a, sh_a, busy_a, done_a, err_a, eidx_a}), 64'd0);
    q_a.delete();
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      stuck_a = vecs[i].stuck;
      start_session_a(vecs[i].verify, 1'b0, 32'h0);
      for (int p = 0; p < (vecs[i].verify ? 2 : 1); p++) begin
        send_word(1'b0, vecs[i].w0, 32);
        if (vecs[i].gap > 0) begin
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!ready_a && t < 100);
          repeat (vecs[i].gap) @(posedge clk);
          #1;
        end
        send_word(1'b0, vecs[i].w1, 32);
      end
      finish_session_a(vecs[i].exp_sh, vecs[i].exp_hs, vecs[i].exp_err, vecs[i].exp_idx);
      if (!vecs[i].stuck) check("chain_a", chain_a, exp_chain(vecs[i].w0, vecs[i].w1));
    end
    stuck_a = 1'b0;

    // 40-flop chain: only the top 8 bits of the second word are shifted.
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    @(negedge clk);
    check("start_busy_b", 64'(busy_b), 64'd1);
    shifts_b = 0; hs_b = 0;
    @(posedge clk); #1;
    send_word(1'b1, 32'hFFFF_FFFF, 32);
    send_word(1'b1, 32'hAB00_0000, 8);
    t = 0;
    while (!done_b && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    check("done_b", 64'(done_b), 64'd1);
    check("shift_count_b", 64'(shifts_b), 64'd40);
    check("handshakes_b", 64'(hs_b), 64'd2);
    check("sb_drained_b", 64'(q_b.size()), 64'd0);
    check("chain_b_low", 64'(chain_b[31:0]), 64'hFFFF_FFFF);
    for (int k = 32; k < 40; k++) byte_b[7-(k-32)] = chain_b[k];
    check("chain_b_last_byte", 64'(byte_b), 64'hAB);
    check("shift_count_a_idle", 64'(sh_a), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ccff_stream_loader.md
Name: ccff_stream_loader

Overview:
- Configuration-chain driver that feeds `ccff_head` of the first routing/connection block in a tile column. Every chain flop is clocked by `prog_clk`.
- Accepts bitstream words over a valid/ready interface, serialises them MSB-first onto `ccff_head`, and issues a shift enable per bit. The top level uses that enable as the ICG enable for the chain's `prog_clk`.
- An optional verify pass re-streams the same words and compares the returned `ccff_tail` bit by bit.

Parameters:
- WORD_W, 32, width of each bitstream word.
- CHAIN_LEN, 64, number of flops in the attached chain (16 muxes x 4 SRAM bits).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived; do not override).

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- pReset  in  1  synchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; starts a session (ignored unless IDLE or DONE).
- cfg_verify  in  1  sampled with `cfg_start`; 1 = run a verify pass after the load pass.
- cfg_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- cfg_valid  in  1  `cfg_data` valid.
- cfg_ready  out  1  word accepted when valid&&ready.
- ccff_head  out  1  serial data into the chain.
- ccff_tail  in  1  serial data from the chain end.
- ccff_shift_en  out  1  chain clock enable; the chain advances exactly one bit on each `prog_clk` edge with this high.
- busy  out  1  high in LOAD or VERIFY.
- done  out  1  high in DONE state.
- err  out  1  sticky verify mismatch.
- err_idx  out  CNT_W  stream index of the first mismatching bit.

Behaviour:
- Reset (pReset=1 at a `prog_clk` edge) forces:
  - state=IDLE, with all outputs 0 (`cfg_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `err`, `err_idx`).
  - Internal registers cleared: shift register, bit count, word-bit count, verify flag.
  - This applies mid-session too; the partially loaded chain is simply left as-is.
- States: IDLE, LOAD, VERIFY, DONE.
  - IDLE/DONE --cfg_start--> LOAD. This clears `err`, `err_idx` and the bit counter, and latches `cfg_verify`.
  - LOAD --CHAIN_LEN bits shifted--> VERIFY if the latched verify flag is set, else DONE. The bit counter clears on entry to VERIFY.
  - VERIFY --CHAIN_LEN bits shifted--> DONE.
  - `cfg_start` while busy is ignored.
- Words per pass = ceil(CHAIN_LEN/WORD_W).
  - In the last word only the top (CHAIN_LEN - (words-1)*WORD_W) bits are used; the low bits are discarded.
  - The host supplies the identical word sequence again for VERIFY.
- Data path: WORD_W shift register plus a remaining-bits count.
  - `cfg_ready` = busy && (count==0 || (count==1 && ccff_shift_en)). This gives a back-to-back refill with no bubble.
  - A word is never accepted after the pass's final bit has been consumed.
- `ccff_head` = shift register MSB, registered. `ccff_shift_en` = busy && count!=0.
  - One bit per cycle. The bit counter increments on each shift.
  - A valid gap stalls the chain (`ccff_shift_en`=0); `ccff_head` holds its value.
- Latency: a word accepted at edge t drives its first bit with `ccff_shift_en`=1 in cycle t+1.
  - A fully streamed 64-bit load takes 64 shift cycles plus 1 fill cycle.
- Verify compare: in VERIFY, on each shifting cycle with stream index k, compare `ccff_tail` against `ccff_head` (bit k of the resend).
  - Valid because the tail shows pass-1 bit k after exactly CHAIN_LEN shifts.
  - On the first mismatch, set `err`=1 and `err_idx`=k. Later mismatches do not update `err_idx`.
  - `err` is sticky until the next `cfg_start` or reset.
- `done` is a level, held until `cfg_start` or reset.
- Simultaneous `cfg_start` and `cfg_valid` in IDLE: the word is not accepted that cycle (`cfg_ready`=0 in IDLE).
- Counters saturate only by the state change; no wrap-around is possible within a pass.

Decomposition:
- Shared package `ccff_pkg` holds:
  - the state enum typedef (IDLE/LOAD/VERIFY/DONE);
  - a localparam function for words-per-pass;
  - the default CHAIN_LEN constant for `cbx` tiles.
- One natural sub-module: `ccff_word_serializer` (WORD_W shift register, remaining count, ready logic, head/shift_en generation).
- The FSM, bit counter and verify comparator remain in the top.

Test Plan:
- Reset: hold pReset 2 cycles mid-LOAD after 10 shifts -> next cycle all outputs 0, state IDLE; a new `cfg_start` loads the full 64 bits correctly.
- Load, no verify, continuous valid: words 0xA5A5_0F0F, 0x1234_5678 -> exactly 64 `ccff_shift_en` cycles; the chain model holds bit0=1 ... matching MSB-first order; `done`=1 on the cycle after the 64th shift; `cfg_ready` high for exactly 2 handshakes.
- Backpressure/gaps: `cfg_valid` deasserted 5 cycles between words -> `ccff_shift_en`=0 for those cycles, head stable; the chain contents are identical to the gap-free case.
- Verify pass, good chain (64-flop model): `cfg_verify`=1, same two words sent twice -> 128 shifts total, `err`=0, `done`=1.
- Verify pass, faulty model (flop 20 stuck-at-0, data bit 20 = 1) -> `err`=1 and `err_idx`=20 at that cycle; `err_idx` unchanged by later mismatches; `err` cleared by the next `cfg_start`.
- Partial last word: CHAIN_LEN=40, WORD_W=32, words 0xFFFF_FFFF, 0xAB00_0000 -> exactly 40 shifts; the last 8 chain bits = 0xAB; low 24 bits never appear on `ccff_head` with shift_en high.
